seq_divider: RTL
================

// Module: seq_divider
// PURPOSE
//  Multi-cycle radix-2 restoring divider. It is the inverse companion of the
//  Booth multiplier: given dividend and divisor it returns quotient and remainder.
//  Produces one quotient bit per clock. Sits beside the multiplier in the
//  arithmetic datapath and uses a start/done handshake.
// PARAMETERS
//  WIDTH  8  operand, quotient and remainder width in bits (>= 2)
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_i          in   1      reset, asynchronous, active-high
//  start_i        in   1      request; sampled only in IDLE
//  dividend_i     in   WIDTH  dividend, captured on accepted start
//  divisor_i      in   WIDTH  divisor, captured on accepted start
//  busy_o         out  1      high in every state except IDLE
//  done_o         out  1      one-cycle pulse: results valid
//  quotient_o     out  WIDTH  quotient, held until next accepted start
//  remainder_o    out  WIDTH  remainder, held until next accepted start
//  div_by_zero_o  out  1      divisor was 0 for the current result; held like results
// BEHAVIOUR
//  - Reset: FSM goes to IDLE. All outputs and internal registers are cleared to 0.
//  - FSM states: IDLE, CALC, FIX, DONE.
//    * IDLE -> CALC when start_i=1 and divisor_i!=0.
//    * IDLE -> DONE when start_i=1 and divisor_i==0.
//    * CALC -> FIX after exactly WIDTH cycles; a down-counter runs WIDTH-1..0.
//    * FIX -> DONE.
//    * DONE -> IDLE.
//  - Normal latency: done_o is high WIDTH+2 cycles after the edge that accepted
//    start, i.e. it is high during the DONE state.
//  - Start handling:
//    * start_i is ignored while busy_o=1. No queueing.
//    * start_i in the DONE cycle is also ignored.
//    * A new start is accepted the cycle after DONE at the earliest.
//  - Accept: operands are converted to magnitudes (WIDTH-bit unsigned) and
//    result signs are registered:
//    * q_neg = sign(dividend) XOR sign(divisor)
//    * r_neg = sign(dividend)
//  - CALC step, per cycle:
//    * rem is WIDTH+1 bits: {rem, next dividend MSB} - divisor_mag.
//    * If the result is non-negative, keep it and shift in a quotient bit of 1.
//    * Otherwise restore and shift in 0.
//  - FIX: apply two's-complement negation to the quotient if q_neg and to the
//    remainder if r_neg.
//    * Truncation is toward zero.
//    * The remainder sign equals the dividend sign; remainder is 0 when exact.
//  - Overflow: most-negative / -1 (e.g. -128/-1 at WIDTH=8) yields quotient
//    0x80 (wrapped) and remainder 0, with no flag.
//  - Divide by zero:
//    * quotient_o = all ones; remainder_o = dividend_i unchanged.
//    * div_by_zero_o = 1; done_o pulses 1 cycle after accept.
//  - Output timing:
//    * quotient_o, remainder_o and div_by_zero_o update only when entering DONE.
//    * They are stable and meaningful whenever done_o=1, and held afterwards.
//  - Reset mid-operation: the operation is aborted immediately and no done_o is
//    produced. Outputs go to 0.
// CONFIGURATION
//  DIV_SIGNED_EN
//  - Defined: operands and results are two's-complement signed; FIX applies
//    sign correction as above.
//  - Undefined: operands are unsigned.
//    * FIX performs no correction but is still 1 cycle, so latency is unchanged.
//    * No overflow case exists.
//    * Divide-by-zero still gives all-ones quotient and remainder = dividend.
// TESTING
//  1. Signed: 100/7 -> q=14, r=2, done_o exactly 10 cycles after accept
//     (WIDTH=8). Then -100/7 -> q=-14 (0xF2), r=-2 (0xFE).
//  2. Signed: -128/-1 -> q=0x80, r=0, div_by_zero_o=0. Also 100/-7 -> q=-14, r=2.
//  3. 55/0 -> done_o 1 cycle after accept, q=0xFF, r=55, div_by_zero_o=1.
//     The next valid op clears the flag.
//  4. Assert start_i with new operands each cycle while busy and in DONE ->
//     only the first op runs, and the result matches the first operands.
//  5. Assert rst_i asynchronously mid-CALC -> outputs immediately 0, busy_o=0,
//     no done_o pulse. A following 9/3 gives q=3, r=0.
//  6. Without DIV_SIGNED_EN: 200/7 -> q=28, r=4; 255/255 -> q=1, r=0.
//     Latency is identical to the signed build.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: radix-2 restoring divider, one quotient bit per clock, start/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned.
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] dvd, dsr, rem, dvd_mag, dsr_mag;
  logic q_neg, r_neg, sd, ss;
  logic [WIDTH+1:0] diff;
`ifdef DIV_SIGNED_EN
  assign sd = dividend_i[WIDTH-1];
  assign ss = divisor_i[WIDTH-1];
`else
  assign sd = 1'b0;
  assign ss = 1'b0;
`endif
  assign dvd_mag = sd ? -dividend_i : dividend_i;
  assign dsr_mag = ss ? -divisor_i : divisor_i;
  // dvd shifts dividend bits out of the top while quotient bits enter at the bottom
  assign diff = {1'b0, rem, dvd[WIDTH-1]} - {2'b00, dsr};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      dvd           <= '0;
      dsr           <= '0;
      rem           <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      quotient_o    <= '0;
      remainder_o   <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i && divisor_i == '0) begin
            state         <= DONE;
            busy_o        <= 1'b1;
            done_o        <= 1'b1;
            quotient_o    <= '1;
            remainder_o   <= dividend_i;
            div_by_zero_o <= 1'b1;
          end else if (start_i) begin
            state  <= CALC;
            busy_o <= 1'b1;
            cnt    <= CW'(WIDTH - 1);
            dvd    <= dvd_mag;
            dsr    <= dsr_mag;
            rem    <= '0;
            q_neg  <= sd ^ ss;
            r_neg  <= sd;
          end
        end
        CALC: begin
          rem   <= diff[WIDTH+1] ? {rem[WIDTH-2:0], dvd[WIDTH-1]} : diff[WIDTH-1:0];
          dvd   <= {dvd[WIDTH-2:0], ~diff[WIDTH+1]};
          cnt   <= cnt - 1'b1;
          state <= cnt == '0 ? FIX : CALC;
        end
        FIX: begin
          state         <= DONE;
          done_o        <= 1'b1;
          quotient_o    <= q_neg ? -dvd : dvd;
          remainder_o   <= r_neg ? -rem : rem;
          div_by_zero_o <= 1'b0;
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
